// File: rtl/radix4_seq_multiplier.sv
// Iterative radix-4 multiplier: one 2-bit multiplier digit per cycle, valid/ready on both sides.
// Define RADIX4_MULT_SIGNED_EN for two's-complement operands and product (default: unsigned).
module radix4_seq_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned NDIG = WIDTH / 2;
    localparam int unsigned CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NDIG - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("radix4_seq_multiplier: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [PW-1:0]     r_acc;
    logic [CNTW-1:0]   r_cnt;
    logic [PW-1:0]     r_product;
    logic [PW-1:0]     w_partial;
    logic [PW-1:0]     w_acc_next;
    logic [PW-1:0]     w_result;
    logic [WIDTH-1:0]  w_a_mag;
    logic [WIDTH-1:0]  w_b_mag;
    logic              w_last;

`ifdef RADIX4_MULT_SIGNED_EN
    logic r_sign;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    assign w_a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign w_result = r_sign ? (~w_acc_next + 1'b1) : w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
        end else if (r_state == StIdle && in_valid) begin
            r_sign <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign w_a_mag  = a;
    assign w_b_mag  = b;
    assign w_result = w_acc_next;
`endif

    assign w_last     = (r_cnt == LAST);
    assign w_acc_next = r_acc + w_partial;

    always_comb begin
        w_partial = '0;
        unique case (r_mplier[1:0])
            2'd0: w_partial = '0;
            2'd1: w_partial = r_mcand;
            2'd2: w_partial = r_mcand << 1;
            2'd3: w_partial = r_mcand + (r_mcand << 1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (in_valid) w_state_next = StCalc;
            StCalc: if (w_last) w_state_next = StDone;
            StDone: if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == StIdle);
        busy      = (r_state == StCalc);
        out_valid = (r_state == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                StCalc: begin
                    r_mcand  <= r_mcand << 2;
                    r_mplier <= r_mplier >> 2;
                    r_acc    <= w_acc_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) r_product <= w_result;
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule
